insfetch: RTL
=============

INSFETCH -- requirements
Module: insfetch

Interface
REQ-001 SHALL have ports, in order: clk_in (in, 1, single clock, rising edge); rst_n_in (in, 1, reset, asynchronous, active-low); rdy_in (in, 1, global enable).
REQ-002 SHALL have icache ports: ic_req (out, 1, fetch request); ic_addr (out, 32, fetch address); ic_valid (in, 1, one-cycle response strobe); ic_ins (in, 32, instruction word).
REQ-003 SHALL have decoder ports: is_ins (out, 1, instruction valid); ins_addr (out, 32, instruction pc); ins (out, 32, instruction word); pred_jmp (out, 1, predicted taken); pred_another (out, 32, non-chosen successor address); f_stall (in, 1, decoder cannot accept).
REQ-004 SHALL have ROB ports: rob_clear (in, 1, flush/redirect); rob_new_pc (in, 32, redirect target); bp_upd (in, 1, branch resolved); bp_upd_pc (in, 32, resolved branch pc); bp_upd_taken (in, 1, actual outcome).

Function
REQ-005 SHALL hold a 32-bit pc and a state register with states IDLE, WAIT, HOLD and FLUSH; all outputs SHALL be registered.
REQ-006 When rdy_in=0, no register SHALL change, except through asynchronous reset.
REQ-007 IDLE: ic_req<=1, ic_addr<=pc, goto WAIT.
REQ-008 WAIT: ic_req and ic_addr held; on ic_valid=1: ic_req<=0, ins<=ic_ins, ins_addr<=pc, is_ins<=1, load prediction outputs, goto HOLD.
REQ-009 HOLD: while f_stall=1, is_ins, ins, ins_addr, pred_jmp and pred_another SHALL stay stable and no request SHALL be issued; the first cycle with f_stall=0 is the transfer cycle.
REQ-010 After a transfer: is_ins<=0, pc<=predicted next pc, goto IDLE. Minimum spacing between transfers is 4 cycles with 1-cycle icache latency.
REQ-011 The predictor SHALL be a 16-entry table of 2-bit saturating counters, indexed by pc[5:2]; taken when counter[1]=1.
REQ-012 Prediction, by ic_ins[6:0]:
- B-type (0x63): taken target = pc + immB, where immB is the sign-extended 13-bit value {ins[31],ins[7],ins[30:25],ins[11:8],0}. If predicted taken: pred_jmp=1, next=target, pred_another=pc+4. Otherwise: pred_jmp=0, next=pc+4, pred_another=target.
- JAL (0x6F): pred_jmp=1, next=pc+immJ, pred_another=pc+4.
- JALR (0x67) and all other opcodes: pred_jmp=0, next=pc+4, pred_another=pc+4.
REQ-013 All address arithmetic SHALL be 32-bit modulo 2^32; 0xFFFFFFFC+4 wraps to 0.
REQ-014 When bp_upd=1, the counter at bp_upd_pc[5:2] SHALL increment if bp_upd_taken=1 and decrement otherwise, saturating at 3 and 0.
REQ-015 If a table read and a table update hit the same index in the same cycle, the read SHALL see the pre-update value.
REQ-016 rob_clear=1 (with rdy_in=1) SHALL override every other event in that cycle, including a transfer cycle:
- is_ins<=0, ic_req<=0, pc<=rob_new_pc;
- from WAIT with no ic_valid in that cycle: goto FLUSH; otherwise goto IDLE.
REQ-017 FLUSH: discard the next ic_valid response, then goto IDLE. A further rob_clear while in FLUSH SHALL update pc and remain in FLUSH.
REQ-018 ic_valid outside WAIT and FLUSH SHALL be ignored.

Reset
REQ-019 While rst_n_in=0, asynchronously: pc=0, state=IDLE, ic_req=0, ic_addr=0, is_ins=0, ins=0, ins_addr=0, pred_jmp=0, pred_another=0, all counters=2'b01.
REQ-020 Reset asserted in any state, including mid-request or mid-HOLD, SHALL abort the operation; after release, fetching SHALL restart at pc 0 with the first ic_req in the first active cycle.

Verification
REQ-021 Release reset; icache answers ic_ins=0x00000013 after 1 cycle; f_stall=0 -> is_ins=1, ins_addr=0, ins=0x13, pred_jmp=0, pred_another=4; next ic_addr=0x4.
REQ-022 Redirect to pc 0x100; ic_ins=0x0100006F (jal x0,+16) -> pred_jmp=1, pred_another=0x104; next ic_addr=0x110.
REQ-023 pc 0x20, ic_ins=0xFE000CE3 (beq -8), counter[8]=01 -> pred_jmp=0, pred_another=0x18. Apply two bp_upd(pc 0x20, taken=1), then refetch -> pred_jmp=1, pred_another=0x24, next ic_addr=0x18.
REQ-024 Hold f_stall=1 for 5 cycles in HOLD -> outputs unchanged and ic_req=0 throughout; drop f_stall -> exactly one transfer cycle, then is_ins=0.
REQ-025 rob_clear with rob_new_pc=0x200 in WAIT, stale ic_valid arriving 2 cycles later -> no is_ins for the stale word; next ic_addr=0x200.
REQ-026 rob_clear in the same cycle as a HOLD transfer -> pc=rob_new_pc, not the predicted next pc. Assert rst_n_in mid-HOLD -> is_ins=0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/insfetch.sv
// Instruction fetch unit: one outstanding icache request, decoder hand-off
// with stall hold, ROB redirect/flush and a 16-entry 2-bit branch predictor.
module insfetch (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    output logic        ic_req,
    output logic [31:0] ic_addr,
    input  logic        ic_valid,
    input  logic [31:0] ic_ins,
    output logic        is_ins,
    output logic [31:0] ins_addr,
    output logic [31:0] ins,
    output logic        pred_jmp,
    output logic [31:0] pred_another,
    input  logic        f_stall,
    input  logic        rob_clear,
    input  logic [31:0] rob_new_pc,
    input  logic        bp_upd,
    input  logic [31:0] bp_upd_pc,
    input  logic        bp_upd_taken
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2,
        FLUSH = 2'd3
    } state_t;

    localparam logic [6:0] OP_BR  = 7'h63;
    localparam logic [6:0] OP_JAL = 7'h6F;

    state_t      state_q;
    state_t      state_d;
    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] next_pc_q;
    logic [31:0] next_pc_d;

    logic        ic_req_d;
    logic [31:0] ic_addr_d;
    logic        is_ins_d;
    logic [31:0] ins_addr_d;
    logic [31:0] ins_d;
    logic        pred_jmp_d;
    logic [31:0] pred_another_d;

    logic [1:0]  cnt_q [16];
    logic [3:0]  upd_idx;
    logic [1:0]  cnt_rd;

    logic [31:0] imm_b;
    logic [31:0] imm_j;
    logic [31:0] seq_pc;
    logic [31:0] br_tgt;
    logic [31:0] jal_tgt;
    logic        pr_jmp;
    logic [31:0] pr_next;
    logic [31:0] pr_other;

    logic        unused_upd_bits;

    assign unused_upd_bits = ^{bp_upd_pc[31:6], bp_upd_pc[1:0]};
    assign upd_idx = bp_upd_pc[5:2];
    // Read the registered counter so a same-cycle update is not visible yet
    assign cnt_rd  = cnt_q[pc_q[5:2]];

    assign imm_b = {{19{ic_ins[31]}}, ic_ins[31], ic_ins[7],
                    ic_ins[30:25], ic_ins[11:8], 1'b0};
    assign imm_j = {{11{ic_ins[31]}}, ic_ins[31], ic_ins[19:12],
                    ic_ins[20], ic_ins[30:21], 1'b0};

    assign seq_pc  = pc_q + 32'd4;
    assign br_tgt  = pc_q + imm_b;
    assign jal_tgt = pc_q + imm_j;

    always_comb begin
        pr_jmp   = 1'b0;
        pr_next  = seq_pc;
        pr_other = seq_pc;
        case (ic_ins[6:0])
            OP_BR: begin
                if (cnt_rd[1]) begin
                    pr_jmp  = 1'b1;
                    pr_next = br_tgt;
                end else begin
                    pr_other = br_tgt;
                end
            end
            OP_JAL: begin
                pr_jmp  = 1'b1;
                pr_next = jal_tgt;
            end
            default: begin
            end
        endcase
    end

    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        next_pc_d      = next_pc_q;
        ic_req_d       = ic_req;
        ic_addr_d      = ic_addr;
        is_ins_d       = is_ins;
        ins_addr_d     = ins_addr;
        ins_d          = ins;
        pred_jmp_d     = pred_jmp;
        pred_another_d = pred_another;

        if (rob_clear) begin
            is_ins_d = 1'b0;
            ic_req_d = 1'b0;
            pc_d     = rob_new_pc;
            // A request still in flight must have its answer swallowed
            if ((state_q == WAIT || state_q == FLUSH) && !ic_valid) begin
                state_d = FLUSH;
            end else begin
                state_d = IDLE;
            end
        end else begin
            case (state_q)
                IDLE: begin
                    ic_req_d  = 1'b1;
                    ic_addr_d = pc_q;
                    state_d   = WAIT;
                end
                WAIT: begin
                    if (ic_valid) begin
                        ic_req_d       = 1'b0;
                        ins_d          = ic_ins;
                        ins_addr_d     = pc_q;
                        is_ins_d       = 1'b1;
                        pred_jmp_d     = pr_jmp;
                        pred_another_d = pr_other;
                        next_pc_d      = pr_next;
                        state_d        = HOLD;
                    end
                end
                HOLD: begin
                    if (!f_stall) begin
                        is_ins_d = 1'b0;
                        pc_d     = next_pc_q;
                        state_d  = IDLE;
                    end
                end
                FLUSH: begin
                    if (ic_valid) begin
                        state_d = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= IDLE;
            pc_q         <= 32'd0;
            next_pc_q    <= 32'd0;
            ic_req       <= 1'b0;
            ic_addr      <= 32'd0;
            is_ins       <= 1'b0;
            ins_addr     <= 32'd0;
            ins          <= 32'd0;
            pred_jmp     <= 1'b0;
            pred_another <= 32'd0;
        end else if (rdy_in) begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            next_pc_q    <= next_pc_d;
            ic_req       <= ic_req_d;
            ic_addr      <= ic_addr_d;
            is_ins       <= is_ins_d;
            ins_addr     <= ins_addr_d;
            ins          <= ins_d;
            pred_jmp     <= pred_jmp_d;
            pred_another <= pred_another_d;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < 16; i++) begin
                cnt_q[i] <= 2'b01;
            end
        end else if (rdy_in && bp_upd) begin
            if (bp_upd_taken) begin
                if (cnt_q[upd_idx] != 2'b11) begin
                    cnt_q[upd_idx] <= cnt_q[upd_idx] + 2'b01;
                end
            end else if (cnt_q[upd_idx] != 2'b00) begin
                cnt_q[upd_idx] <= cnt_q[upd_idx] - 2'b01;
            end
        end
    end

endmodule
